regfile8_16bit: RTL and testbench
=================================

Name: regfile8_16bit

Overview:
- 8-entry x 16-bit register file: the storage stage directly upstream of the datapath's 8:1 16-bit operand selector.
- Exposes all eight register contents in parallel (q0..q7) so the downstream selector picks one with its 3-bit select.
- Also provides two internal read ports (A/B) for the ALU operand path.
- One synchronous write port with enable and 3-bit address decode.

Parameters:
- WIDTH, 16, data width of every register.
- ZERO_R0, 0, when 1, register 0 is hardwired to zero and writes to it are ignored.
- RESET_VAL, 16'h0000, value loaded into every register on reset.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- we  input  1  write enable
- waddr  input  3  write address
- wdata  input  WIDTH  write data
- raddr_a  input  3  read port A address
- raddr_b  input  3  read port B address
- rdata_a  output  WIDTH  read port A data
- rdata_b  output  WIDTH  read port B data
- q0..q7  output  WIDTH each  parallel register contents, feeding the 8:1 selector inputs in0..in7

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - rst_n low forces all eight registers to RESET_VAL immediately, without waiting for clk.
  - With ZERO_R0=1, register 0 is always 0 regardless of RESET_VAL.
  - Reset dominates any write in the same cycle.
  - Release is synchronous to clk: the first write is accepted on the first rising edge with rst_n high.
- Write:
  - On a rising clk with we=1, register[waddr] <= wdata.
  - All other registers hold.
  - we=0 means no register changes, whatever waddr/wdata are.
  - Latency is 1 cycle: the new value is visible on q[waddr] and on any read port addressing it immediately after the edge.
- Decode:
  - 3-to-8 one-hot decode of waddr, gated by we.
  - Exactly one register enable is active when we=1; none when we=0.
- Read:
  - rdata_a = register[raddr_a] and rdata_b = register[raddr_b], purely combinational.
  - No write-to-read bypass: reading the address being written in the same cycle returns the old value until the edge.
- Ports may alias:
  - raddr_a == raddr_b gives identical data on both ports.
  - A read port may equal waddr; the no-bypass rule above applies.
- ZERO_R0=1:
  - Writes to address 0 are dropped.
  - q0, and any read of address 0, is 0.
- Register storage:
  - Each bit is a D flip-flop with enable, built as a 2:1 feedback mux ahead of the flop.
  - No glitch-dependent behaviour; all state changes occur only on clk edges or on reset assertion.
- Reset mid-operation: asserting rst_n while we=1 discards the write; registers show RESET_VAL for as long as rst_n is low.
- All widths are WIDTH bits; no truncation or extension is performed.

Decomposition:
- Shared package:
  - REG_COUNT=8
  - REG_ADDR_W=3
  - DATA_W=16
  - RESET_VAL constant
- Sub-module register16_en: one WIDTH-bit register with clk, rst_n, en, d, q.
  - Instantiated 8 times; the register 0 instance is replaced by a constant when ZERO_R0=1.
- Read ports reuse the existing 16-bit 8:1 selector, one instance per port.
- The 3-to-8 write decoder is a small local sub-block, decoder3to8_en.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with we=1, wdata=16'hFFFF, waddr=3 -> q0..q7 all 16'h0000 immediately (before next clk); after release, q3 still 16'h0000.
- Write/readback: write 16'h1234 to addr 5, then 16'hABCD to addr 2 -> q5=16'h1234, q2=16'hABCD, others 0; raddr_a=5, raddr_b=2 gives rdata_a=16'h1234, rdata_b=16'hABCD.
- No bypass: reg7=16'h0001, then write 16'h00FF to addr 7 with raddr_a=7 -> rdata_a=16'h0001 before the edge, 16'h00FF after.
- we=0: waddr=4, wdata=16'hDEAD, we=0 for 3 cycles -> q4 unchanged (16'h0000); no other register changes.
- ZERO_R0=1: write 16'h5555 to addr 0 -> q0=0 and rdata_a(raddr_a=0)=0; a write of 16'h5555 to addr 1 succeeds.
- Back-to-back writes: write addr 0..7 with values 16'h0010*i on 8 consecutive cycles -> each qi=16'h0010*i exactly one cycle after its write; earlier registers unaffected by later writes.

Source files
------------

// File: rtl/regfile8_16bit_pkg.sv
// Shared sizing constants for the 8 x 16-bit register file and its helper cells.
package regfile8_16bit_pkg;
  localparam int REG_COUNT  = 8;
  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;
  localparam logic [DATA_W-1:0] DEF_RESET_VAL = 16'h0000;
endpackage

// File: rtl/regfile8_16bit_cells.sv
// Building blocks of the register file: enabled register, gated write decoder,
// and the 16-bit 8:1 operand selector used by both read ports.
module register16_en #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_d;

  // Explicit feedback mux ahead of the flop provides the hold path.
  assign w_d = en ? d : r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= RESET_VAL;
    else        r_q <= w_d;
  end

  assign q = r_q;
endmodule

module decoder3to8_en (
  input  logic       en,
  input  logic [2:0] addr,
  output logic [7:0] onehot
);
  for (genvar gi = 0; gi < 8; gi++) begin : g_dec
    assign onehot[gi] = en && (addr == 3'(gi));
  end
endmodule

module mux8to1_16 #(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = in0;
    case (sel)
      3'd0: y = in0;
      3'd1: y = in1;
      3'd2: y = in2;
      3'd3: y = in3;
      3'd4: y = in4;
      3'd5: y = in5;
      3'd6: y = in6;
      3'd7: y = in7;
      default: y = in0;
    endcase
  end
endmodule

// File: rtl/regfile8_16bit.sv
// 8 x WIDTH register file: one enabled write port, two combinational read ports
// (no write bypass) and all eight registers exposed in parallel.
module regfile8_16bit
  import regfile8_16bit_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter bit ZERO_R0 = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = DEF_RESET_VAL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]      rdata_a,
  output logic [WIDTH-1:0]      rdata_b,
  output logic [WIDTH-1:0]      q0,
  output logic [WIDTH-1:0]      q1,
  output logic [WIDTH-1:0]      q2,
  output logic [WIDTH-1:0]      q3,
  output logic [WIDTH-1:0]      q4,
  output logic [WIDTH-1:0]      q5,
  output logic [WIDTH-1:0]      q6,
  output logic [WIDTH-1:0]      q7
);
  logic [REG_COUNT-1:0] w_wen;
  logic [WIDTH-1:0]     w_q [REG_COUNT];

  decoder3to8_en u_dec (
    .en     (we),
    .addr   (waddr),
    .onehot (w_wen)
  );

  for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
    if (gi == 0 && ZERO_R0) begin : g_zero
      assign w_q[gi] = '0;
    end else begin : g_flop
      register16_en #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_wen[gi]),
        .d     (wdata),
        .q     (w_q[gi])
      );
    end
  end

  assign q0 = w_q[0];
  assign q1 = w_q[1];
  assign q2 = w_q[2];
  assign q3 = w_q[3];
  assign q4 = w_q[4];
  assign q5 = w_q[5];
  assign q6 = w_q[6];
  assign q7 = w_q[7];

  mux8to1_16 #(.WIDTH(WIDTH)) u_rd_a (
    .sel (raddr_a),
    .in0 (w_q[0]), .in1 (w_q[1]), .in2 (w_q[2]), .in3 (w_q[3]),
    .in4 (w_q[4]), .in5 (w_q[5]), .in6 (w_q[6]), .in7 (w_q[7]),
    .y   (rdata_a)
  );

  mux8to1_16 #(.WIDTH(WIDTH)) u_rd_b (
    .sel (raddr_b),
    .in0 (w_q[0]), .in1 (w_q[1]), .in2 (w_q[2]), .in3 (w_q[3]),
    .in4 (w_q[4]), .in5 (w_q[5]), .in6 (w_q[6]), .in7 (w_q[7]),
    .y   (rdata_b)
  );
endmodule

// File: tb/tb_regfile8_16bit.sv
// Bench for regfile8_16bit: one instance with a normal r0 and one with r0 tied
// to zero, both driven identically and compared against array models.
module tb_regfile8_16bit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;

  logic [15:0] rda_n, rdb_n, rda_z, rdb_z;
  logic [15:0] qn0, qn1, qn2, qn3, qn4, qn5, qn6, qn7;
  logic [15:0] qz0, qz1, qz2, qz3, qz4, qz5, qz6, qz7;

  logic [15:0] m_n [8];
  logic [15:0] m_z [8];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  regfile8_16bit #(.ZERO_R0(1'b0)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda_n), .rdata_b(rdb_n),
    .q0(qn0), .q1(qn1), .q2(qn2), .q3(qn3), .q4(qn4), .q5(qn5), .q6(qn6), .q7(qn7)
  );

  regfile8_16bit #(.ZERO_R0(1'b1)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda_z), .rdata_b(rdb_z),
    .q0(qz0), .q1(qz1), .q2(qz2), .q3(qz3), .q4(qz4), .q5(qz5), .q6(qz6), .q7(qz7)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h expected=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] qn [8];
    logic [15:0] qz [8];
    qn = '{qn0, qn1, qn2, qn3, qn4, qn5, qn6, qn7};
    qz = '{qz0, qz1, qz2, qz3, qz4, qz5, qz6, qz7};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s.n.q%0d", tag, i), qn[i], m_n[i]);
      check($sformatf("%s.z.q%0d", tag, i), qz[i], m_z[i]);
    end
    check({tag, ".n.rda"}, rda_n, m_n[raddr_a]);
    check({tag, ".n.rdb"}, rdb_n, m_n[raddr_b]);
    check({tag, ".z.rda"}, rda_z, m_z[raddr_a]);
    check({tag, ".z.rdb"}, rdb_z, m_z[raddr_b]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_n[i] = 16'h0000;
      m_z[i] = 16'h0000;
    end
  endtask

  // Advance one clock; the model takes the write that the edge commits.
  task automatic tick();
    if (rst_n && we) begin
      m_n[waddr] = wdata;
      if (waddr != 3'd0) m_z[waddr] = wdata;
      $display("[TB] write addr=%0d data=%h", waddr, wdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [2:0] ra, input logic [2:0] rb);
    we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_init");
    rst_n = 1'b1;

    // Put nonzero data in place so asynchronous reset is observable.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 16'hA000 + 16'(i), 3'(i), 3'(7 - i));
      tick();
    end
    check_all("prefill");

    // Asynchronous reset mid-cycle with a pending write.
    drive(1'b1, 3'd3, 16'hFFFF, 3'd3, 3'd0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset_async");
    tick();
    check_all("reset_held");
    #2;
    we = 1'b0;
    rst_n = 1'b1;
    tick();
    check("reset_release.q3", qn3, 16'h0000);
    check_all("reset_release");

    // Write / readback.
    drive(1'b1, 3'd5, 16'h1234, 3'd5, 3'd2); tick();
    drive(1'b1, 3'd2, 16'hABCD, 3'd5, 3'd2); tick();
    check("wr.rda", rda_n, 16'h1234);
    check("wr.rdb", rdb_n, 16'hABCD);
    check_all("write_readback");

    // No write-to-read bypass.
    drive(1'b1, 3'd7, 16'h0001, 3'd7, 3'd7); tick();
    drive(1'b1, 3'd7, 16'h00FF, 3'd7, 3'd7);
    #1;
    check("nobypass.before", rda_n, 16'h0001);
    check_all("nobypass_before");
    tick();
    check("nobypass.after", rda_n, 16'h00FF);

    // we=0 holds everything.
    drive(1'b0, 3'd4, 16'hDEAD, 3'd4, 3'd1);
    repeat (3) tick();
    check("we0.q4", qn4, 16'h0000);
    check_all("we0");

    // r0 tied to zero in the ZERO_R0 instance.
    drive(1'b1, 3'd0, 16'h5555, 3'd0, 3'd1); tick();
    check("zr0.q0", qz0, 16'h0000);
    check("zr0.rda", rda_z, 16'h0000);
    drive(1'b1, 3'd1, 16'h5555, 3'd0, 3'd1); tick();
    check("zr0.q1", qz1, 16'h5555);
    check_all("zero_r0");

    // Back-to-back writes across all addresses.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 16'(16'h0010 * i), 3'(i), 3'(i));
      tick();
      check($sformatf("b2b.rda%0d", i), rda_n, 16'(16'h0010 * i));
      check_all($sformatf("b2b%0d", i));
    end

    // Randomized traffic, including occasional mid-cycle resets.
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
            3'($urandom), 3'($urandom));
      #1;
      check_all("rnd_pre");
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rnd_rst");
        tick();
        #2;
        rst_n = 1'b1;
      end else begin
        tick();
      end
      check_all("rnd_post");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
